// File: rtl/uart_debug_pkg.sv
// rtl/uart_debug_pkg.sv - opcodes, reply codes and command FSM states for the UART debug bridge
package uart_debug_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_REPLY
    } state_e;

endpackage

// File: rtl/uart_byte_phy.sv
// rtl/uart_byte_phy.sv - 8N1 byte deserializer and serializer with a valid/ready byte interface
module uart_byte_phy
    import uart_debug_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] rx_tdata,
    output logic       rx_tvalid,
    input  logic [7:0] tx_tdata,
    input  logic       tx_tvalid,
    output logic       tx_tready,
    output logic       tx_active
);

    localparam int CW = $clog2(DIV);

    logic          rx_s1_q, rx_s2_q, rx_s3_q;
    logic          rx_act_q;
    logic [CW-1:0] rx_cnt_q;
    logic [3:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic          rx_valid_q;

    logic          tx_act_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_bit_q;
    logic [9:0]    tx_frame_q;

    assign rx_tdata  = rx_shift_q;
    assign rx_tvalid = rx_valid_q;
    assign tx_tready = !tx_act_q;
    assign tx_active = tx_act_q;
    assign tx        = tx_frame_q[0];

    // Two-flop synchronizer, plus a third stage used only for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    // Deserializer: slot 0 re-checks the start bit at mid-bit, slots 1-8 are data, slot 9 is stop
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_act_q   <= 1'b0;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (!rx_act_q) begin
                if (rx_s3_q && !rx_s2_q) begin
                    rx_act_q <= 1'b1;
                    rx_cnt_q <= CW'(DIV / 2 - 1);
                    rx_bit_q <= '0;
                end
            end else if (rx_cnt_q != '0) begin
                rx_cnt_q <= rx_cnt_q - 1'b1;
            end else begin
                rx_cnt_q <= CW'(DIV - 1);
                rx_bit_q <= rx_bit_q + 4'd1;
                if (rx_bit_q == 4'd0) begin
                    // a start bit that is high again at mid-bit was only a glitch
                    if (rx_s2_q) rx_act_q <= 1'b0;
                end else if (rx_bit_q < 4'd9) begin
                    rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                end else begin
                    rx_act_q   <= 1'b0;
                    rx_valid_q <= rx_s2_q;
                end
            end
        end
    end

    // Serializer: the frame register idles all ones so the line rests high
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_act_q   <= 1'b0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_frame_q <= '1;
        end else if (!tx_act_q) begin
            if (tx_tvalid) begin
                tx_frame_q <= {1'b1, tx_tdata, 1'b0};
                tx_cnt_q   <= CW'(DIV - 1);
                tx_bit_q   <= '0;
                tx_act_q   <= 1'b1;
            end
        end else if (tx_cnt_q != '0) begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
        end else if (tx_bit_q == 4'd9) begin
            tx_act_q <= 1'b0;
        end else begin
            tx_frame_q <= {1'b1, tx_frame_q[9:1]};
            tx_bit_q   <= tx_bit_q + 4'd1;
            tx_cnt_q   <= CW'(DIV - 1);
        end
    end

endmodule

// File: rtl/uart_debug_bridge.sv
// rtl/uart_debug_bridge.sv - host UART command decoder issuing single-word bus reads and writes
module uart_debug_bridge
    import uart_debug_pkg::*;
#(
    parameter int CLOCK_FREQ     = 100000000,
    parameter int BAUD_RATE      = 115200,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        tx,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        busy
);

    localparam int DIV = CLOCK_FREQ / BAUD_RATE;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    logic [7:0] rx_tdata;
    logic       rx_tvalid;
    logic [7:0] tx_tdata;
    logic       tx_tvalid;
    logic       tx_tready;
    logic       tx_active;

    state_e        state_q, state_d;
    logic          is_wr_q, is_wr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rsp_q, rsp_d;
    logic [2:0]    rsp_n_q, rsp_n_d;
    logic [TW-1:0] to_q, to_d;
    logic          timed_out;

    uart_byte_phy #(.DIV(DIV)) u_phy (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .tx        (tx),
        .rx_tdata  (rx_tdata),
        .rx_tvalid (rx_tvalid),
        .tx_tdata  (tx_tdata),
        .tx_tvalid (tx_tvalid),
        .tx_tready (tx_tready),
        .tx_active (tx_active)
    );

    // The request is a pure function of the state, so it can never outlive BUS
    assign bus_rd    = (state_q == ST_BUS) && !is_wr_q;
    assign bus_wr    = (state_q == ST_BUS) && is_wr_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign busy      = (state_q != ST_IDLE) || tx_active;
    assign timed_out = (to_q == TW'(TIMEOUT_CYCLES - 1));

    // Command sequencing, reply queueing and timeout tracking
    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rsp_d     = rsp_q;
        rsp_n_d   = rsp_n_q;
        tx_tvalid = 1'b0;
        tx_tdata  = rsp_q[7:0];
        case (state_q)
            ST_IDLE: begin
                if (rx_tvalid) begin
                    if (rx_tdata == OP_WRITE || rx_tdata == OP_READ) begin
                        is_wr_d = (rx_tdata == OP_WRITE);
                        cnt_d   = '0;
                        state_d = ST_ADDR;
                    end else begin
                        rsp_d   = {24'h0, RSP_NAK};
                        rsp_n_d = 3'd1;
                        state_d = ST_REPLY;
                    end
                end
            end
            ST_ADDR: begin
                if (rx_tvalid) begin
                    addr_d = {rx_tdata, addr_q[31:8]};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = is_wr_q ? ST_DATA : ST_BUS;
                end else if (timed_out) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (rx_tvalid) begin
                    wdata_d = {rx_tdata, wdata_q[31:8]};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = ST_BUS;
                end else if (timed_out) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (bus_ack) begin
                    rsp_d   = is_wr_q ? {24'h0, RSP_ACK} : bus_rdata;
                    rsp_n_d = is_wr_q ? 3'd1 : 3'd4;
                    state_d = ST_REPLY;
                end else if (timed_out) begin
                    rsp_d   = {24'h0, RSP_NAK};
                    rsp_n_d = 3'd1;
                    state_d = ST_REPLY;
                end
            end
            ST_REPLY: begin
                if (rsp_n_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    tx_tvalid = 1'b1;
                    if (tx_tready) begin
                        rsp_d   = {8'h00, rsp_q[31:8]};
                        rsp_n_d = rsp_n_q - 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q || rx_tvalid) begin
            to_d = '0;
        end else if (state_q == ST_ADDR || state_q == ST_DATA || state_q == ST_BUS) begin
            to_d = to_q + TW'(1);
        end else begin
            to_d = '0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            is_wr_q <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rsp_q   <= '0;
            rsp_n_q <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rsp_q   <= rsp_d;
            rsp_n_q <= rsp_n_d;
            to_q    <= to_d;
        end
    end

endmodule

// File: doc/uart_debug_bridge.md
# uart_debug_bridge

UART-side bus initiator that sits beside `Grande_Risco_5_SOC` on the board top level and drives the opposite end of the host serial link. It deserializes 8N1 command frames from a host PC, issues single-word reads or writes on a simple req/ack memory bus into the SoC, and serializes replies back. It is used for program loading and memory inspection without a JTAG probe.

## Interface
- `CLOCK_FREQ`, 100000000: system clock in Hz.
- `BAUD_RATE`, 115200: serial bit rate. `DIV = CLOCK_FREQ/BAUD_RATE`, integer-truncated, must be ≥ 4.
- `TIMEOUT_CYCLES`, 1000000: maximum idle cycles between bytes of one command, and maximum bus-ack wait.
- `clk` input 1: system clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `rx` input 1: serial in from host, asynchronous.
- `tx` output 1: serial out to host.
- `bus_rd` output 1: read request, held until ack.
- `bus_wr` output 1: write request, held until ack.
- `bus_addr` output 32: byte address.
- `bus_wdata` output 32: write data.
- `bus_rdata` input 32: read data, valid in the cycle `bus_ack`=1.
- `bus_ack` input 1: one-cycle completion strobe.
- `busy` output 1: high from the first accepted command byte until the last reply byte's stop bit ends.

## Operation
- **RX path**
  - `rx` passes through a 2-flop synchronizer.
  - A falling edge in IDLE starts the bit counter. The start bit is re-checked at `DIV/2`; if it is high, the frame is a glitch and is discarded.
  - Data bits are sampled every `DIV` cycles thereafter, LSB first.
  - If the stop bit samples 0, the byte is dropped (framing error) and the command FSM is not notified.
  - A good byte produces a one-cycle `rx_valid` strobe.
- **TX path**
  - Idle line is 1.
  - Each byte is sent as start(0), 8 data bits LSB first, stop(1), each bit `DIV` cycles long.
  - The serializer accepts a new byte only when idle.
- **Command FSM states:** IDLE, ADDR, DATA, BUS, REPLY.
- **IDLE**
  - 0x57 ('W') or 0x52 ('R'): latch opcode, go to ADDR.
  - Any other byte: queue NAK 0x15, go to REPLY.
- **ADDR:** collect 4 bytes, LSB first, into `bus_addr`. Then W goes to DATA and R goes to BUS.
- **DATA:** collect 4 bytes, LSB first, into `bus_wdata`, then go to BUS.
- **BUS**
  - Assert `bus_wr` (W) or `bus_rd` (R); hold it until `bus_ack`.
  - On ack, W queues ACK 0x06. R latches `bus_rdata` and queues its 4 bytes LSB first.
  - Then go to REPLY.
- **REPLY:** send the queued bytes back-to-back, then go to IDLE.
  - RX bytes arriving in REPLY are discarded.
  - RX bytes arriving in BUS are discarded.
- **Timeouts**
  - In ADDR or DATA, `TIMEOUT_CYCLES` without a good byte returns the FSM to IDLE silently.
  - In BUS, `TIMEOUT_CYCLES` without `bus_ack` drops the request and queues NAK 0x15.
  - The timeout counter clears on every state change and every good byte.
- Address alignment is not checked; the bus owns alignment.

## Timing
- **Reset values:** `tx`=1, `bus_rd`=0, `bus_wr`=0, `bus_addr`=0, `bus_wdata`=0, `busy`=0, FSM in IDLE. All counters are 0.
- Reset mid-frame aborts everything. A partial TX byte is truncated and the line returns to 1 the cycle after reset.
- **Bus request timing**
  - `bus_rd`/`bus_wr` rise in the cycle after entering BUS.
  - Address and data are stable while the request is high.
  - The request drops in the cycle after `bus_ack` is sampled.
  - Ack is accepted in the same cycle as the request's first high cycle; zero wait states are legal.
  - `bus_rd` and `bus_wr` are never both high.
- `bus_ack` while no request is pending is ignored.
- Reply TX start bit begins ≤ 2 cycles after the bus ack, or after the NAK decision.
- Gap between reply bytes is ≤ 1 cycle.
- A byte completes with its `rx_valid` strobe `9*DIV + DIV/2` (±1) cycles after the start-bit falling edge at the synchronizer output.

## Structure
- A shared package `uart_debug_pkg` holds:
  - opcode constants `OP_WRITE`=8'h57 and `OP_READ`=8'h52;
  - reply constants `RSP_ACK`=8'h06 and `RSP_NAK`=8'h15;
  - the FSM state enum.
- One sub-module, `uart_byte_phy`, holds the RX synchronizer and deserializer and the TX serializer. It shares the `DIV` parameter and has a valid/ready byte interface.
- The command FSM, 4-byte reply shift register and timeout counter live in `uart_debug_bridge`.

## Test plan
Bench uses `CLOCK_FREQ`=1000000, `BAUD_RATE`=100000 (`DIV`=10) and `TIMEOUT_CYCLES`=500.
- **Write:** send 57 10 00 00 00 EF BE AD DE, slave acks after 3 cycles.
  - Exactly one `bus_wr` pulse with `bus_addr`=0x00000010 and `bus_wdata`=0xDEADBEEF.
  - `tx` returns 0x06.
- **Read:** send 52 10 00 00 00, slave returns 0x12345678 with zero wait states.
  - `bus_rd` is high exactly 1 cycle.
  - `tx` returns 78 56 34 12.
- **Bad opcode:** send 0x41.
  - `tx` returns 0x15.
  - No bus activity.
  - `busy` falls after the stop bit.
- **Inter-byte timeout:** send 57 10 00, then idle for 600 cycles.
  - No bus activity and no TX.
  - A following valid read command succeeds.
- **Stuck bus:** never ack a read.
  - `bus_rd` drops after 500 cycles.
  - `tx` returns 0x15.
- **Error cases:**
  - A frame with stop bit = 0 produces no byte.
  - A 3-cycle low glitch on `rx` produces no byte.
  - Reset asserted mid-reply drives `tx`=1 the next cycle and `busy`=0.
